// File: rtl/controller_pkg.sv
// Shared types and constants for the serial gamepad poller.
// Contents: poll FSM state enum, MMIO controller word width and layout,
// and button bit positions within the held/pressed halves of that word.
package controller_pkg;

  localparam int unsigned CTRL_WORD_W = 32;
  localparam int unsigned BTN_W       = 16;

  // Button bit positions (same index in the held and newly-pressed halves)
  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_Y      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } poll_state_e;

  // Controller word as seen by MMIO: upper half edges, lower half levels
  typedef struct packed {
    logic [BTN_W-1:0] pressed;
    logic [BTN_W-1:0] held;
  } ctrl_word_t;

endpackage

// File: rtl/clk_tick_gen.sv
// Protocol tick divider: one-cycle registered tick every DIV clocks while
// enabled. clear_i restarts the count so the first tick lands exactly DIV
// cycles after the clear.
// Ports: clk_i, reset_i (sync, active-high), clear_i, en_i, tick_o.
// DIV must be >= 2 (the tick is registered one count early).
module clk_tick_gen #(
  parameter int unsigned DIV = 300
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..DIV-1; raise the registered tick while the count sits at DIV-1
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d  = (cnt_q == CNT_W'(DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_W'(DIV - 2));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/controller_poller.sv
// Serial gamepad front end: periodically latches and clocks a shift-register
// pad (active-low data), resynchronises the data line, and publishes a
// 32-bit word {newly pressed, held} with a one-cycle valid strobe.
// Ports: clock_i, reset_i (sync, active-high), poll_en_i, pad_data_i (async,
//   active-low) in; pad_latch_o, pad_clk_o (idles high), buttons_o[31:0],
//   buttons_valid_o, pad_present_o, busy_o out.
// Build option: CONTROLLER_DEBOUNCE_EN makes a held bit change only when two
//   consecutive present polls agree on it.
module controller_poller
  import controller_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 300,
  parameter int unsigned NUM_BITS    = 16,
  parameter int unsigned POLL_PERIOD = 833333
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   poll_en_i,
  input  logic                   pad_data_i,
  output logic                   pad_latch_o,
  output logic                   pad_clk_o,
  output logic [CTRL_WORD_W-1:0] buttons_o,
  output logic                   buttons_valid_o,
  output logic                   pad_present_o,
  output logic                   busy_o
);

  localparam int unsigned POLL_W = $clog2(POLL_PERIOD);
  localparam int unsigned BIT_W  = 4;

  poll_state_e      state_q, state_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic             sync1_q, sync2_q;
  logic             latch_tick_q, latch_tick_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [BTN_W-1:0] raw_q, raw_d;
  ctrl_word_t       buttons_q, buttons_d;
  logic             valid_q, valid_d;
  logic             present_q, present_d;
  logic             pad_latch_q, pad_latch_d;
  logic             pad_clk_q, pad_clk_d;
  logic             busy_q, busy_d;

  logic             tick_c;
  logic             start_c;
  logic             sample_c;
  logic             present_c;
  logic [BTN_W-1:0] new_state_c;

`ifdef CONTROLLER_DEBOUNCE_EN
  logic [BTN_W-1:0] prev_raw_q, prev_raw_d;
  logic [BTN_W-1:0] agree_c;
`endif

  clk_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk_i   (clock_i),
    .reset_i (reset_i),
    .clear_i (start_c),
    .en_i    (state_q != IDLE),
    .tick_o  (tick_c)
  );

  // Free-running poll timer; a wrap only starts a poll when idle and enabled
  always_comb begin
    poll_cnt_d = (poll_cnt_q == POLL_W'(POLL_PERIOD - 1)) ? '0 : poll_cnt_q + POLL_W'(1);
    start_c    = (poll_cnt_q == POLL_W'(POLL_PERIOD - 1)) && poll_en_i && (state_q == IDLE);
  end

  // Active-low pad line to active-high "pressed"
  assign sample_c = ~sync2_q;

  // Missing pad with pull-down reads the always-unused top bits as pressed
  always_comb begin
    present_c = (raw_q[NUM_BITS-1 -: 4] == 4'b0000);
`ifdef CONTROLLER_DEBOUNCE_EN
    agree_c     = ~(raw_q ^ prev_raw_q);
    new_state_c = (raw_q & agree_c) | (buttons_q.held & ~agree_c);
    prev_raw_d  = prev_raw_q;
    if ((state_q == DONE) && present_c) begin
      prev_raw_d = raw_q;
    end
`else
    new_state_c = raw_q;
`endif
  end

  // Poll sequencer
  always_comb begin
    state_d      = state_q;
    latch_tick_d = latch_tick_q;
    bit_idx_d    = bit_idx_q;
    raw_d        = raw_q;
    buttons_d    = buttons_q;
    present_d    = present_q;
    valid_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d      = LATCH;
          latch_tick_d = 1'b0;
          bit_idx_d    = '0;
          raw_d        = '0;
        end
      end
      LATCH: begin
        if (tick_c) begin
          if (latch_tick_q) begin
            raw_d[0]  = sample_c;
            bit_idx_d = BIT_W'(1);
            state_d   = CLK_LO;
          end else begin
            latch_tick_d = 1'b1;
          end
        end
      end
      CLK_LO: begin
        if (tick_c) begin
          state_d = CLK_HI;
        end
      end
      CLK_HI: begin
        if (tick_c) begin
          raw_d[bit_idx_q] = sample_c;
          if (bit_idx_q == BIT_W'(NUM_BITS - 1)) begin
            state_d = DONE;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            state_d   = CLK_LO;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        valid_d   = 1'b1;
        present_d = present_c;
        if (present_c) begin
          buttons_d.pressed = new_state_c & ~buttons_q.held;
          buttons_d.held    = new_state_c;
        end else begin
          buttons_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad-facing and status outputs follow the next state so they change with it
  always_comb begin
    pad_latch_d = (state_d == LATCH);
    pad_clk_d   = (state_d != CLK_LO);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      poll_cnt_q   <= '0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      latch_tick_q <= 1'b0;
      bit_idx_q    <= '0;
      raw_q        <= '0;
      buttons_q    <= '0;
      valid_q      <= 1'b0;
      present_q    <= 1'b0;
      pad_latch_q  <= 1'b0;
      pad_clk_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      poll_cnt_q   <= poll_cnt_d;
      sync1_q      <= pad_data_i;
      sync2_q      <= sync1_q;
      latch_tick_q <= latch_tick_d;
      bit_idx_q    <= bit_idx_d;
      raw_q        <= raw_d;
      buttons_q    <= buttons_d;
      valid_q      <= valid_d;
      present_q    <= present_d;
      pad_latch_q  <= pad_latch_d;
      pad_clk_q    <= pad_clk_d;
      busy_q       <= busy_d;
    end
  end

`ifdef CONTROLLER_DEBOUNCE_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_raw_q <= '0;
    end else begin
      prev_raw_q <= prev_raw_d;
    end
  end
`endif

  assign pad_latch_o     = pad_latch_q;
  assign pad_clk_o       = pad_clk_q;
  assign buttons_o       = buttons_q;
  assign buttons_valid_o = valid_q;
  assign pad_present_o   = present_q;
  assign busy_o          = busy_q;

endmodule
